// File: rtl/nlane_link.sv
// nlane_link: serialises a word over LANES data lines with sclk/cs_n and deserialises it back
module nlane_link #(
    parameter int DATA_WIDTH = 64,
    parameter int LANES = 2,
    parameter int CLK_DIV = 2,
    localparam int BEATS = DATA_WIDTH / LANES,
    localparam int BW = $clog2(BEATS + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [BW-1:0]         in_beats,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  sclk,
    output logic                  cs_n,
    output logic [LANES-1:0]      lanes
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] left;
    logic [DATA_WIDTH-1:0] tx, rx, tx_next;
    logic [BW-1:0] n_eff;
    logic div_done;
    assign in_ready = state == IDLE && rstn;
    assign n_eff = (in_beats == '0 || in_beats > BW'(BEATS)) ? BW'(BEATS) : in_beats;
    assign tx_next = tx << LANES;
    assign div_done = cnt == CW'(CLK_DIV - 1);
    // rx samples the lanes on the internal LOW->HIGH step, not on an sclk edge detect
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            cnt <= '0;
            left <= '0;
            tx <= '0;
            rx <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            sclk <= 1'b0;
            cs_n <= 1'b1;
            lanes <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    tx <= in_data;
                    left <= n_eff;
                    cs_n <= 1'b0;
                    sclk <= 1'b0;
                    lanes <= in_data[DATA_WIDTH-1 -: LANES];
                    rx <= '0;
                    cnt <= '0;
                    state <= LOW;
                end
                LOW: if (div_done) begin
                    cnt <= '0;
                    sclk <= 1'b1;
                    rx <= (rx << LANES) | DATA_WIDTH'(lanes);
                    state <= HIGH;
                end else cnt <= cnt + 1'b1;
                HIGH: if (div_done) begin
                    cnt <= '0;
                    sclk <= 1'b0;
                    if (left == BW'(1)) begin
                        cs_n <= 1'b1;
                        lanes <= '0;
                        out_data <= rx;
                        out_valid <= 1'b1;
                        state <= IDLE;
                    end else begin
                        left <= left - 1'b1;
                        tx <= tx_next;
                        lanes <= tx_next[DATA_WIDTH-1 -: LANES];
                        state <= LOW;
                    end
                end else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nlane_link.sv
// tb_nlane_link: four link configurations driven by directed and random transfers against a word-level model
`define CHK(tag, obs, exp) begin tests++; assert ((obs) === (exp)) else begin fails++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end end
module tb_nlane_link;
    function automatic int lanes_of(int g);
        return g == 0 ? 2 : g == 1 ? 1 : g == 2 ? 4 : 8;
    endfunction
    function automatic int div_of(int g);
        return g == 0 ? 2 : g == 1 ? 3 : g == 2 ? 1 : 3;
    endfunction
    logic clk, rstn;
    logic in_valid_s [4], in_ready_s [4], out_valid_s [4], sclk_s [4], cs_n_s [4];
    logic [63:0] in_data_s [4], out_data_s [4];
    logic [7:0] in_beats_s [4], lanes_s [4];
    int tests = 0, fails = 0;
    for (genvar g = 0; g < 4; g++) begin : u
        localparam int L = lanes_of(g);
        localparam int D = div_of(g);
        localparam int W = $clog2(64 / L + 1);
        logic [L-1:0] lw;
        nlane_link #(.DATA_WIDTH(64), .LANES(L), .CLK_DIV(D)) dut (
            .clk(clk), .rstn(rstn), .in_valid(in_valid_s[g]), .in_ready(in_ready_s[g]),
            .in_data(in_data_s[g]), .in_beats(in_beats_s[g][W-1:0]), .out_valid(out_valid_s[g]),
            .out_data(out_data_s[g]), .sclk(sclk_s[g]), .cs_n(cs_n_s[g]), .lanes(lw));
        assign lanes_s[g] = 8'(lw);
    end
    initial clk = 0;
    always #5 clk = ~clk;
    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal;
    end
    // Called just after a negedge with the link idle; returns at the negedge where out_valid is seen
    task automatic xfer(int k, logic [63:0] d, int b, bit keep);
        int L, D, B, n, i, low, rises, tv, bad;
        logic [63:0] exp;
        logic ps;
        logic [7:0] pl;
        bit got;
        L = lanes_of(k); D = div_of(k); B = 64 / L;
        n = (b == 0 || b > B) ? B : b;
        exp = d >> (64 - n * L);
        `CHK("ready", in_ready_s[k], 1'b1)
        in_data_s[k] = d; in_beats_s[k] = 8'(b); in_valid_s[k] = 1;
        @(posedge clk); #1;
        if (!keep) begin
            in_valid_s[k] = 0;
            in_data_s[k] = (64'($urandom) << 32) | 64'($urandom);
            in_beats_s[k] = 8'($urandom);
        end
        i = 0; low = 0; rises = 0; bad = 0; got = 0; tv = -1; ps = 0; pl = lanes_s[k];
        while (!got && i <= 2 * D * n + 4) begin
            @(negedge clk);
            if (!cs_n_s[k]) low++;
            if (sclk_s[k] && !ps) begin
                if (lanes_s[k] !== pl) bad++;
                if (lanes_s[k] !== 8'((d << (rises * L)) >> (64 - L))) bad++;
                rises++;
            end
            if (out_valid_s[k]) begin got = 1; tv = i; end
            in_valid_s[k] = keep || (i == 3 && 2 * D * n > 6);
            ps = sclk_s[k]; pl = lanes_s[k]; i++;
        end
        `CHK("done", got, 1'b1)
        `CHK("latency", tv, 2 * D * n)
        `CHK("cs_low", low, 2 * D * n)
        `CHK("sclk_pulses", rises, n)
        `CHK("lane_beats", bad, 0)
        `CHK("out_data", out_data_s[k], exp)
        if (!keep) begin
            @(negedge clk);
            `CHK("pulse_one", out_valid_s[k], 1'b0)
            `CHK("cs_idle", cs_n_s[k], 1'b1)
            `CHK("hold", out_data_s[k], exp)
        end
    endtask
    initial begin
        int seen;
        logic [63:0] r;
        rstn = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid_s[k] = 0; in_data_s[k] = '0; in_beats_s[k] = '0;
        end
        repeat (3) @(negedge clk);
        `CHK("rst_ready", in_ready_s[0], 1'b0)
        `CHK("rst_valid", out_valid_s[0], 1'b0)
        `CHK("rst_data", out_data_s[0], 64'h0)
        `CHK("rst_sclk", sclk_s[0], 1'b0)
        `CHK("rst_cs", cs_n_s[0], 1'b1)
        `CHK("rst_lanes", lanes_s[0], 8'h0)
        rstn = 1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) `CHK("ready_after_rst", in_ready_s[k], 1'b1)
        xfer(0, 64'hDEADBEEF_01234567, 0, 0);
        r = (64'($urandom) << 32) | 64'($urandom);
        xfer(0, {8'hA5, r[55:0]}, 4, 0);
        xfer(0, 64'h1, 0, 1);
        `CHK("b2b_gap", cs_n_s[0], 1'b1)
        xfer(0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        for (int k = 0; k < 4; k++) begin
            xfer(k, (64'($urandom) << 32) | 64'($urandom), 0, 0);
            xfer(k, (64'($urandom) << 32) | 64'($urandom), 64 / lanes_of(k) + 3, 0);
            for (int j = 0; j < 3; j++)
                xfer(k, (64'($urandom) << 32) | 64'($urandom), $urandom_range(0, 64 / lanes_of(k) + 3), 0);
        end
        // Abort a full transfer during beat 10
        in_data_s[0] = 64'h0123_4567_89AB_CDEF; in_beats_s[0] = 0; in_valid_s[0] = 1;
        @(posedge clk); #1;
        in_valid_s[0] = 0;
        repeat (41) @(negedge clk);
        rstn = 0;
        @(negedge clk);
        `CHK("abort_cs", cs_n_s[0], 1'b1)
        `CHK("abort_sclk", sclk_s[0], 1'b0)
        `CHK("abort_lanes", lanes_s[0], 8'h0)
        `CHK("abort_data", out_data_s[0], 64'h0)
        `CHK("abort_ready", in_ready_s[0], 1'b0)
        rstn = 1;
        seen = 0;
        repeat (140) begin
            @(negedge clk);
            if (out_valid_s[0]) seen++;
        end
        `CHK("abort_no_valid", seen, 0)
        xfer(0, 64'hCAFE_F00D_1357_9BDF, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
